// File: rtl/pwm_nbit.sv
// -----------------------------------------------------------------------------
// pwm_nbit
//
// Fixed-frequency n-bit pulse-width modulator. The period is 2^n clock cycles
// and the output is high for the first d cycles of each period. d is a shadow
// copy of pw_i taken only at the period boundary. A duty change therefore
// never truncates or stretches the pulse that is already in progress.
//
// Ports:
//   clk_i     in   1   sole clock, rising edge
//   resetn_i  in   1   synchronous reset, active low
//   pw_i      in   n   requested pulse width in cycles (0 .. 2^n-1)
//   pwm_o     out  1   registered PWM waveform, pwm_o == (cnt < d)
// -----------------------------------------------------------------------------
module pwm_nbit #(
  parameter int n = 8
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic [n-1:0] pw_i,
  output logic         pwm_o
);

  localparam logic [n-1:0] CntMax = '1;

  logic [n-1:0] cnt_q, cnt_d;
  logic [n-1:0] duty_q, duty_d;
  logic         pwm_q, pwm_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    cnt_d  = cnt_q + n'(1);
    duty_d = duty_q;
    // The shadow register is loaded on the wrap edge only, so the period that
    // starts at cnt == 0 sees the pw_i value present at that boundary.
    if (cnt_q == CntMax) begin
      duty_d = pw_i;
    end
    // Compare against the next-state values so the registered output lines up
    // with the counter value it describes, without a cycle of lag.
    pwm_d = (cnt_d < duty_d);
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!resetn_i) begin
      cnt_q  <= '0;
      duty_q <= '0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: tb/tb_pwm_nbit.sv
// -----------------------------------------------------------------------------
// tb_pwm_nbit
//
// Directed bench for pwm_nbit with n = 4 (16-cycle period). Outputs are
// sampled 1 time unit after each rising edge. The bench tracks the period
// position itself, so each 16-cycle window lines up with cnt = 0..15.
// -----------------------------------------------------------------------------
module tb_pwm_nbit;

  localparam int N = 4;
  localparam int P = 1 << N;

  logic         clk = 1'b0;
  logic         resetn;
  logic [N-1:0] pw;
  logic         pwm;

  int n_checks = 0;
  int n_errors = 0;
  int bcnt     = 0;   // bench's own notion of the period position
  int cur_d    = 0;   // duty expected for the period in progress
  int hi       = 0;

  pwm_nbit #(.n(N)) dut (
    .clk_i    (clk),
    .resetn_i (resetn),
    .pw_i     (pw),
    .pwm_o    (pwm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle; keep the bench period position in step.
  task automatic tick();
    @(posedge clk);
    if (!resetn) bcnt = 0;
    else         bcnt = (bcnt + 1) % P;
    #1;
  endtask

  // Sample one full period starting at cnt == 0. Bit k of the pattern is
  // pwm_o during cnt == k. pw_i may be changed in the middle at chg_at.
  task automatic run_period(input string tag, input logic [15:0] exp,
                            input int chg_at = -1,
                            input logic [N-1:0] chg_val = '0);
    logic [15:0] pat;
    pat = '0;
    for (int k = 0; k < P; k++) begin
      if (k == chg_at) pw = chg_val;
      pat[k] = pwm;
      tick();
    end
    check(tag, {16'b0, pat}, {16'b0, exp});
  endtask

  initial begin
    resetn = 1'b0;
    pw     = '0;

    // Reset held 5 cycles: output low throughout.
    for (int i = 0; i < 5; i++) begin
      tick();
      check("reset_low", {31'b0, pwm}, 32'd0);
    end
    resetn = 1'b1;

    // pw = 0: every period stays low.
    run_period("pw0_p1", 16'h0000);
    run_period("pw0_p2", 16'h0000);

    // pw = 4: the period in flight still uses d = 0, the following ones 25 %.
    pw = 4'd4;
    run_period("pw4_pending", 16'h0000);
    run_period("pw4_p1", 16'h000F);
    run_period("pw4_p2", 16'h000F);

    // pw = 15: one low cycle per period, back to back.
    pw = 4'd15;
    run_period("pw15_pending", 16'h000F);
    run_period("pw15_p1", 16'h7FFF);
    run_period("pw15_p2", 16'h7FFF);

    // Change 8 -> 2 at cnt = 5: current period keeps 8, next has 2.
    pw = 4'd8;
    run_period("pw8_pending", 16'h7FFF);
    run_period("pw8_midchg", 16'h00FF, 5, 4'd2);
    run_period("pw2_after", 16'h0003);
    run_period("pw2_again", 16'h0003);

    // Sweep: pw = floor(i*16/100), each held 50 cycles, truncated to 4 bits.
    cur_d = 2;
    hi    = 0;
    for (int j = 0; j < 101 * 50; j++) begin
      pw = N'((j / 50) * 16 / 100);
      hi += int'(pwm);
      if (bcnt == P - 1) begin
        check("sweep_high", hi, cur_d);
        hi    = 0;
        cur_d = int'(pw);
      end
      tick();
    end

    // Realign to a period start with pw = 10 latched at that boundary.
    pw = 4'd10;
    for (int k = 0; k < 2 * P && bcnt != 0; k++) tick();
    check("realign", bcnt, 0);
    run_period("pw10", 16'h03FF);

    // Reset pulse in the middle of a high phase with d = 10.
    for (int k = 0; k < 3; k++) tick();
    check("pre_rst_high", {31'b0, pwm}, 32'd1);
    resetn = 1'b0;
    tick();
    check("rst_pulse_low", {31'b0, pwm}, 32'd0);
    resetn = 1'b1;
    pw     = 4'd6;
    run_period("post_rst_p0", 16'h0000);
    run_period("post_rst_p1", 16'h003F);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
